// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and select encodings for the fetch stage
package cpu_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0004;
  localparam int unsigned IMEM_WORDS = 1024;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [1:0] {PC_SEQ, PC_REDIR, PC_EXC, PC_HOLD} pc_src_e;
  typedef enum logic [1:0] {ID_LOAD, ID_BUBBLE, ID_HOLD, ID_FAULT} id_act_e;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority mux choosing the next pc and the IF/ID action
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter int unsigned IMEM_WORDS = cpu_pkg::IMEM_WORDS
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic        fault_now,
  output logic [31:0] pc4,
  output logic [31:0] pc_next,
  output pc_src_e     pc_src,
  output id_act_e     id_act
);
  localparam logic [31:0] WORDS = 32'(IMEM_WORDS);
  always_comb begin
    pc4 = pc + 32'd4;
    fault_now = (pc[1:0] != 2'b00) | ({2'b00, pc[31:2]} >= WORDS);
    pc_src = exc_req ? PC_EXC : redirect ? PC_REDIR : (stall | fault_now) ? PC_HOLD : PC_SEQ;
    id_act = (exc_req | redirect) ? ID_BUBBLE : stall ? ID_HOLD : fault_now ? ID_FAULT : ID_LOAD;
    pc_next = pc_src == PC_EXC ? EXC_VECTOR : pc_src == PC_REDIR ? redirect_pc :
              pc_src == PC_SEQ ? pc4 : pc;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction RAM interface and IF/ID register
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter int unsigned IMEM_WORDS = cpu_pkg::IMEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_ena,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_fault,
  output logic [31:0] fetch_cnt
);
  logic        fault_now;
  logic [31:0] pc4;
  logic [31:0] pc_next;
  pc_src_e     pc_src;
  id_act_e     id_act;
  pc_next_sel #(.EXC_VECTOR(EXC_VECTOR), .IMEM_WORDS(IMEM_WORDS)) u_sel (
    .pc(pc),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .exc_req(exc_req),
    .fault_now(fault_now),
    .pc4(pc4),
    .pc_next(pc_next),
    .pc_src(pc_src),
    .id_act(id_act)
  );
  always_comb begin
    imem_addr = pc;
    imem_ena = rst_n & ~fault_now;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc <= 32'd0;
      id_pc4 <= 32'd0;
      id_fault <= 1'b0;
      fetch_cnt <= 32'd0;
    end else begin
      pc <= pc_next;
      if (id_act == ID_LOAD) begin
        id_valid <= 1'b1;
        id_instr <= imem_data;
        id_pc <= pc;
        id_pc4 <= pc4;
        id_fault <= 1'b0;
        fetch_cnt <= fetch_cnt + 32'd1;
      end else if (id_act == ID_FAULT) begin
        id_valid <= 1'b1;
        id_instr <= NOP_INSTR;
        id_pc <= pc;
        id_pc4 <= pc4;
        id_fault <= 1'b1;
      end else if (id_act == ID_BUBBLE) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
        id_fault <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch sequence checked against a behavioural model via a scoreboard
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ena;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        exc_req = 1'b0;
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_fault;
  logic [31:0] fetch_cnt;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] idpc;
    logic [31:0] idpc4;
    logic        f;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t m;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_ena(imem_ena), .imem_addr(imem_addr),
    .imem_data(imem_data), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc_req(exc_req), .pc(pc), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4), .id_fault(id_fault),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;
  always_comb imem_data = mem[imem_addr[11:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic e, input logic rn);
    exp_t x;
    logic flt;
    stall = s;
    redirect = r;
    redirect_pc = rp;
    exc_req = e;
    rst_n = rn;
    #1;
    flt = (m.pc[1:0] != 2'b00) || (m.pc >= 32'h0000_1000);
    chk("imem_addr", imem_addr, m.pc);
    chk("imem_ena", {31'd0, imem_ena}, {31'd0, rn && !flt});
    x = m;
    if (!rn) begin
      x = '{32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0};
    end else if (e || r) begin
      x.pc = e ? 32'h4 : rp;
      x.v = 1'b0;
      x.instr = 32'd0;
      x.f = 1'b0;
    end else if (s) begin
      x = m;
    end else if (flt) begin
      x.v = 1'b1;
      x.instr = 32'd0;
      x.f = 1'b1;
      x.idpc = m.pc;
      x.idpc4 = m.pc + 32'd4;
    end else begin
      x.v = 1'b1;
      x.instr = mem[m.pc[11:2]];
      x.f = 1'b0;
      x.idpc = m.pc;
      x.idpc4 = m.pc + 32'd4;
      x.pc = m.pc + 32'd4;
      x.cnt = m.cnt + 32'd1;
    end
    q.push_back(x);
    m = x;
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("pc", pc, x.pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, x.v});
    chk("id_instr", id_instr, x.instr);
    chk("id_pc", id_pc, x.idpc);
    chk("id_pc4", id_pc4, x.idpc4);
    chk("id_fault", {31'd0, id_fault}, {31'd0, x.f});
    chk("fetch_cnt", fetch_cnt, x.cnt);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h3C00_0000 | i;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    m = '{32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0};
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("stall_entry_instr", id_instr, 32'h2009_0002);
    chk("stall_entry_pc", pc, 32'h8);
    repeat (3) step(1, 0, 0, 0, 1);
    chk("stall_hold_cnt", fetch_cnt, 32'd2);
    step(0, 0, 0, 0, 1);
    chk("third_word", id_instr, 32'h0109_5020);
    chk("cnt_three", fetch_cnt, 32'd3);
    step(0, 0, 0, 0, 1);
    step(1, 1, 32'h40, 0, 1);
    chk("redir_bubble", {31'd0, id_valid}, 32'd0);
    step(0, 0, 0, 0, 1);
    chk("redir_idpc", id_pc, 32'h40);
    step(0, 1, 32'h80, 1, 1);
    chk("exc_pc", pc, 32'h4);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'h42, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("mis_fault", {31'd0, id_fault}, 32'd1);
    chk("mis_idpc", id_pc, 32'h42);
    repeat (2) step(0, 0, 0, 0, 1);
    chk("mis_hold", pc, 32'h42);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'hFF8, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    chk("last_word", id_pc, 32'hFFC);
    chk("last_instr", id_instr, 32'h3C00_03FF);
    step(0, 0, 0, 0, 1);
    chk("range_fault", {31'd0, id_fault}, 32'd1);
    chk("range_idpc", id_pc, 32'h1000);
    step(0, 0, 0, 0, 1);
    step(1, 1, 32'h80, 1, 0);
    chk("rst_pc", pc, 32'h0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
